// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and IDLE/ACCESS/RESP sequencer that shares
// a word-wide, byte-addressed data memory between two load/store requesters.
module dmem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              rerr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                pick1_s;
   logic                aligned_s;

   // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
   assign pick1_s   = req1 & (~req0 | ~last_q);
   assign aligned_s = (addr_q[1:0] == 2'b00);

   // State and operand registers; reset returns to IDLE with port 0 favoured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state, grant, memory-pin and response decode; every output defaults to 0.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      rdata     = {DATA_W{1'b0}};
      rerr      = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_read  = 1'b0;
      mem_write = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               gnt0    = ~pick1_s;
               gnt1    = pick1_s;
               owner_d = pick1_s;
               last_d  = pick1_s;
               we_d    = pick1_s ? we1    : we0;
               addr_d  = pick1_s ? addr1  : addr0;
               wdata_d = pick1_s ? wdata1 : wdata0;
               state_d = S_ACCESS;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (aligned_s) begin
               mem_addr  = addr_q;
               mem_wdata = wdata_q;
               mem_read  = ~we_q;
               mem_write = we_q;
               rdata_d   = we_q ? {DATA_W{1'b0}} : mem_rdata;
               err_d     = 1'b0;
            end else begin
               // Misaligned: leave the memory untouched and flag the error.
               rdata_d   = {DATA_W{1'b0}};
               err_d     = 1'b1;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            rvalid0 = ~owner_q;
            rvalid1 = owner_q;
            rdata   = rdata_q;
            rerr    = err_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a response scoreboard; a behavioural
// big-endian byte memory sits on the dmem_arbiter memory pins.
module tb_dmem_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1, rerr, mem_read, mem_write;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
      logic          err;
   } resp_t;

   resp_t exp_q[$];
   resp_t mon_e;
   int    checks = 0;
   int    errors = 0;

   logic [7:0] mem [0:63];
   logic       mem_ready = 1'b0;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rerr(rerr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational big-endian read, store on the clock edge.
   always_comb mem_rdata = {mem[mem_addr], mem[mem_addr + 6'd1],
                            mem[mem_addr + 6'd2], mem[mem_addr + 6'd3]};

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
         mem_ready <= 1'b1;
      end else if (mem_write) begin
         mem[mem_addr]        <= mem_wdata[31:24];
         mem[mem_addr + 6'd1] <= mem_wdata[23:16];
         mem[mem_addr + 6'd2] <= mem_wdata[15:8];
         mem[mem_addr + 6'd3] <= mem_wdata[7:0];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_ctl"}, 32'({gnt0, gnt1, rvalid0, rvalid1, rerr, mem_read, mem_write}), 32'd0);
      chk({name, "_rdata"}, rdata, 32'd0);
      chk({name, "_maddr"}, 32'(mem_addr), 32'd0);
      chk({name, "_mwdata"}, mem_wdata, 32'd0);
   endtask

   // Monitor: pops the scoreboard whenever a response is presented.
   always @(negedge clk) begin
      if (!reset) begin
         chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
         if (rvalid0 | rvalid1) begin
            chk("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rvalid_port", 32'(rvalid1), 32'(mon_e.port));
               chk("rdata", rdata, mon_e.data);
               chk("rerr", 32'(rerr), 32'(mon_e.err));
            end
         end else begin
            chk("rdata_idle", rdata, 32'd0);
            chk("rerr_idle", 32'(rerr), 32'd0);
         end
      end
   end

   task automatic drive(input logic port, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (port) begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end else begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end
   endtask

   // One complete access from an idle arbiter; entered and left just after a posedge.
   task automatic access(input logic port, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         input logic exp_err);
      bit   got;
      logic aligned;
      got     = 1'b0;
      aligned = (a[1:0] == 2'b00);
      drive(port, 1'b1, w, a, d);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ((port ? gnt1 : gnt0) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("gnt_timeout", 32'd0, 32'd1);
         drive(port, 1'b0, 1'b0, 6'd0, 32'd0);
         @(posedge clk); #1;
      end else begin
         exp_q.push_back('{port: port, data: exp_rd, err: exp_err});
         @(posedge clk); #1;
         drive(port, 1'b0, 1'b0, 6'd0, 32'd0);
         @(negedge clk);
         chk("mem_write", 32'(mem_write), 32'(w & aligned));
         chk("mem_read", 32'(mem_read), 32'(~w & aligned));
         chk("mem_addr", 32'(mem_addr), aligned ? 32'(a) : 32'd0);
         if (w) chk("mem_wdata", mem_wdata, aligned ? d : 32'd0);
         @(negedge clk);
         chk("rvalid_latency", 32'(port ? rvalid1 : rvalid0), 32'd1);
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      int    k;
      logic  seq [4];
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 6'd0; addr1 = 6'd0; wdata0 = 32'd0; wdata1 = 32'd0;
      repeat (2) begin @(negedge clk); chk_quiet("in_reset"); end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) begin @(negedge clk); chk_quiet("idle"); end
      @(posedge clk); #1;

      // Store then load at 0x08.
      access(1'b0, 1'b1, 6'h08, 32'hDEADBEEF, 32'h0, 1'b0);
      access(1'b0, 1'b0, 6'h08, 32'h0, 32'hDEADBEEF, 1'b0);

      // Reset brings last back to 1, so the tie sequence starts with port 0.
      pulse_reset();
      seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0; seq[3] = 1'b1;
      k = 0;
      drive(1'b0, 1'b1, 1'b0, 6'h08, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 6'h0C, 32'h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (gnt0 | gnt1) begin
            if (k < 4) begin
               chk("rr_gnt_port", 32'(gnt1), 32'(seq[k]));
               chk("rr_gnt_cycle", 32'(i), 32'(3 * k));
               exp_q.push_back('{port: gnt1, data: gnt1 ? 32'h0C0D0E0F : 32'hDEADBEEF, err: 1'b0});
            end
            k++;
         end
      end
      chk("rr_gnt_count", 32'(k), 32'd4);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 6'h0, 32'h0);

      // Misaligned store is rejected and leaves memory untouched.
      access(1'b1, 1'b1, 6'h05, 32'hFFFFFFFF, 32'h0, 1'b1);
      access(1'b0, 1'b0, 6'h04, 32'h0, 32'h04050607, 1'b0);

      // Last legal word, and the first word is unaffected.
      access(1'b0, 1'b1, 6'h3C, 32'h12345678, 32'h0, 1'b0);
      access(1'b1, 1'b0, 6'h3C, 32'h0, 32'h12345678, 1'b0);
      access(1'b0, 1'b0, 6'h00, 32'h0, 32'h00010203, 1'b0);

      // Reset during the ACCESS cycle of a store aborts it.
      drive(1'b0, 1'b1, 1'b1, 6'h10, 32'hCAFEF00D);
      @(negedge clk);
      chk("abort_gnt", 32'(gnt0), 32'd1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
      @(negedge clk);
      chk("abort_mem_write_before", 32'(mem_write), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_mem_write_after", 32'(mem_write), 32'd0);
      chk("abort_mem_read_after", 32'(mem_read), 32'd0);
      chk("abort_mem_addr_after", 32'(mem_addr), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      access(1'b0, 1'b0, 6'h10, 32'h0, 32'h10111213, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
